// File: rtl/mem_writeback_unit_if.sv
// Pipeline-latch to register-file writeback bus for mem_writeback_unit.
// Bypass signals (bypValid/bypRd/bypData) exist only when WB_BYPASS_EN is defined.
interface mem_writeback_unit_if;
  logic [31:0] alu;
  logic        aluToReg;
  logic [4:0]  rd;
  logic        doutBValid;
  logic [2:0]  loadFmt;
  logic [31:0] memRdata;
  logic        memRdataValid;
  logic        stall;
  logic        rfWe;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;
  logic        loadErr;
`ifdef WB_BYPASS_EN
  logic        bypValid;
  logic [4:0]  bypRd;
  logic [31:0] bypData;

  modport master (
    output alu, aluToReg, rd, doutBValid, loadFmt, memRdata, memRdataValid,
    input  stall, rfWe, rfWaddr, rfWdata, loadErr, bypValid, bypRd, bypData
  );
  modport slave (
    input  alu, aluToReg, rd, doutBValid, loadFmt, memRdata, memRdataValid,
    output stall, rfWe, rfWaddr, rfWdata, loadErr, bypValid, bypRd, bypData
  );
`else
  modport master (
    output alu, aluToReg, rd, doutBValid, loadFmt, memRdata, memRdataValid,
    input  stall, rfWe, rfWaddr, rfWdata, loadErr
  );
  modport slave (
    input  alu, aluToReg, rd, doutBValid, loadFmt, memRdata, memRdataValid,
    output stall, rfWe, rfWaddr, rfWdata, loadErr
  );
`endif
endinterface

// File: rtl/mem_writeback_unit.sv
// Writeback stage: waits on variable-latency load data, formats it and drives the register-file port.
// Optional macro WB_BYPASS_EN adds a combinational forwarding view of the next-edge write.
module mem_writeback_unit #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  mem_writeback_unit_if.slave bus
);

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [RD_W-1:0]     cap_rd, cap_rd_n;
  logic [2:0]          cap_fmt, cap_fmt_n;
  logic [1:0]          cap_lane, cap_lane_n;
  logic                we_q, we_n;
  logic [RD_W-1:0]     waddr_q, waddr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic                err_q, err_n;
  logic                stall_c;
  logic                commit;
  logic [RD_W-1:0]     src_rd;
  logic [2:0]          src_fmt;
  logic [1:0]          src_lane;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_ok;

  function automatic logic [DATA_W-1:0] load_format(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        lane,
                                                    input logic [2:0]        f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_format = {{24{b[7]}}, b};
      3'b001:  load_format = {{16{h[15]}}, h};
      3'b100:  load_format = {24'd0, b};
      3'b101:  load_format = {16'd0, h};
      default: load_format = word;
    endcase
  endfunction

  function automatic logic load_aligned(input logic [1:0] lane, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: load_aligned = 1'b1;
      3'b001, 3'b101: load_aligned = ~lane[0];
      default:        load_aligned = (lane == 2'b00);
    endcase
  endfunction

  // In WAIT the latch may already hold garbage, so the captured copy drives formatting.
  always_comb begin
    src_rd   = (state == WAIT) ? cap_rd   : bus.rd;
    src_fmt  = (state == WAIT) ? cap_fmt  : bus.loadFmt;
    src_lane = (state == WAIT) ? cap_lane : bus.alu[1:0];
    ld_data  = load_format(bus.memRdata, src_lane, src_fmt);
    ld_ok    = load_aligned(src_lane, src_fmt);
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cap_rd_n   = cap_rd;
    cap_fmt_n  = cap_fmt;
    cap_lane_n = cap_lane;
    we_n       = 1'b0;
    waddr_n    = waddr_q;
    wdata_n    = wdata_q;
    err_n      = 1'b0;
    stall_c    = 1'b0;
    commit     = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.doutBValid) begin
          if (bus.aluToReg && (bus.rd != '0)) begin
            we_n    = 1'b1;
            waddr_n = bus.rd;
            wdata_n = bus.alu;
          end
        end else if (bus.memRdataValid) begin
          commit = 1'b1;
        end else begin
          stall_c    = 1'b1;
          cap_rd_n   = bus.rd;
          cap_fmt_n  = bus.loadFmt;
          cap_lane_n = bus.alu[1:0];
          cnt_n      = '0;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        if (bus.memRdataValid) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else if (cnt == LAST_WAIT) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_n   = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Misaligned loads report an error instead of writing; x0 loads are silently dropped.
    if (commit) begin
      if (!ld_ok) begin
        err_n = 1'b1;
      end else if (src_rd != '0) begin
        we_n    = 1'b1;
        waddr_n = src_rd;
        wdata_n = ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_rd   <= '0;
      cap_fmt  <= '0;
      cap_lane <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cap_rd   <= cap_rd_n;
      cap_fmt  <= cap_fmt_n;
      cap_lane <= cap_lane_n;
      we_q     <= we_n;
      waddr_q  <= waddr_n;
      wdata_q  <= wdata_n;
      err_q    <= err_n;
    end
  end

  assign bus.stall   = stall_c;
  assign bus.rfWe    = we_q;
  assign bus.rfWaddr = waddr_q;
  assign bus.rfWdata = wdata_q;
  assign bus.loadErr = err_q;

`ifdef WB_BYPASS_EN
  assign bus.bypValid = we_n && !stall_c && !reset;
  assign bus.bypRd    = waddr_n;
  assign bus.bypData  = wdata_n;
`endif

endmodule
